cos_job_feeder: RTL
===================

// Module: cos_job_feeder
// PURPOSE
//  Upstream operand stage for the cosine accelerator.
//  - Buffers (x, y) jobs from a valid/ready producer in a small FIFO.
//  - Launches one accelerator run per job: drives x/y buses and a 1-cycle start pulse.
//  - Waits for the accelerator's done, captures the 16-bit result, and presents it on a valid/ready result port.
//  - Only one job is in flight at a time; results return in issue order.
// PARAMETERS
//  DEPTH    4    job FIFO entries; power of 2, >= 2
//  X_W      16   width of x operand / acc_x
//  Y_W      8    width of y operand / acc_y
//  R_W      16   width of result
//  TIMEOUT  255  watchdog limit in cycles; used only with COS_FEED_TIMEOUT_EN
// PORTS
//  clk        in   1             single clock; all state updates on rising edge
//  rst        in   1             asynchronous, active-low reset
//  in_valid   in   1             job offered
//  in_ready   out  1             FIFO not full
//  in_x       in   X_W           job x operand
//  in_y       in   Y_W           job y operand (term count)
//  acc_start  out  1             start pulse to accelerator
//  acc_x      out  X_W           x bus to accelerator; held stable from start until done
//  acc_y      out  Y_W           y bus to accelerator; held stable from start until done
//  acc_done   in   1             accelerator finished; acc_out valid this cycle
//  acc_out    in   R_W           accelerator result bus
//  res_valid  out  1             result available
//  res_ready  in   1             consumer accepts result
//  res_data   out  R_W           captured result
//  res_err    out  1             result produced by watchdog (always 0 without macro)
//  busy       out  1             FSM not in IDLE, or FIFO non-empty
//  count      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - FIFO empty, count=0, FSM=IDLE.
//   - acc_start=0, acc_x=0, acc_y=0, res_valid=0, res_data=0, res_err=0.
//   - in_ready=1 once rst is released. A job in flight is abandoned; no result is produced.
//  FIFO:
//   - push when in_valid & in_ready; in_ready = (count != DEPTH).
//   - pop happens on the LAUNCH edge. Push and pop in the same cycle: count unchanged.
//   - Pointers wrap modulo DEPTH. in_x/in_y are ignored while full.
//  FSM (all outputs registered):
//   IDLE   - count>0 -> LAUNCH.
//   LAUNCH - acc_x/acc_y <= FIFO head; acc_start <= 1 for exactly one cycle; pop; -> WAIT.
//   WAIT   - acc_start=0. On acc_done: res_data <= acc_out, res_valid <= 1 -> HOLD.
//            acc_done seen in IDLE/LAUNCH/HOLD is ignored.
//   HOLD   - res_valid held, res_data stable until res_valid & res_ready.
//            On handshake: res_valid <= 0; -> LAUNCH if count>0 (back-to-back), else IDLE.
//  Latency:
//   - Job accepted into an empty, idle block at edge N -> acc_start high during cycle N+2.
//   - acc_done at edge M -> res_valid high from M+1.
//  Backpressure:
//   - While res_ready=0 no new launch occurs; the FIFO keeps accepting until full.
// CONFIGURATION
//  COS_FEED_TIMEOUT_EN defined:
//   - Watchdog counter runs in WAIT and clears on entry to WAIT.
//   - If it reaches TIMEOUT without acc_done: res_data <= {R_W{1'b1}}, res_err <= 1, res_valid <= 1 -> HOLD.
//   - res_err clears on the result handshake.
//   - acc_done arriving in the same cycle as the timeout wins (normal result, res_err=0).
//  COS_FEED_TIMEOUT_EN undefined:
//   - No counter logic; WAIT lasts indefinitely; res_err tied 0.
// TESTING
//  1. Single job x=16'h0400, y=8'd5; acc_done 10 cycles after start with acc_out=16'h0F00
//     -> acc_start exactly 1 cycle, 2 cycles after push; acc_x/acc_y stable until done;
//     res_data=16'h0F00 with res_valid the cycle after done.
//  2. Push 4 jobs back-to-back (DEPTH=4) while the first is in WAIT
//     -> in_ready=0 at count=4; a 5th offer is not accepted; results in push order.
//  3. res_ready=0 for 20 cycles after a result -> res_valid/res_data held; no acc_start;
//     on res_ready=1 the next launch follows in the next cycle.
//  4. Simultaneous push and LAUNCH pop at count=2 -> count stays 2; FIFO wrap verified
//     after 9 jobs with distinct x values.
//  5. rst pulled low during WAIT -> all outputs 0 immediately, count=0; the stale acc_done
//     after release is ignored.
//  6. (COS_FEED_TIMEOUT_EN, TIMEOUT=8) acc_done never asserted -> after 8 WAIT cycles
//     res_data=16'hFFFF, res_err=1; separately, done coincident with timeout -> res_err=0.

Source files
------------

// File: rtl/cos_job_feeder.sv
// rtl/cos_job_feeder.sv - job FIFO and launch/collect sequencer for the cosine accelerator (optional watchdog: COS_FEED_TIMEOUT_EN)
module cos_job_feeder #(
  parameter int DEPTH   = 4,
  parameter int X_W     = 16,
  parameter int Y_W     = 8,
  parameter int R_W     = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [X_W-1:0]         in_x,
  input  logic [Y_W-1:0]         in_y,
  output logic                   acc_start,
  output logic [X_W-1:0]         acc_x,
  output logic [Y_W-1:0]         acc_y,
  input  logic                   acc_done,
  input  logic [R_W-1:0]         acc_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [R_W-1:0]         res_data,
  output logic                   res_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Reject configurations the pointer arithmetic cannot support.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("cos_job_feeder: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  // Job storage; contents need no reset because count gates every read.
  logic [X_W-1:0] x_mem [DEPTH];
  logic [Y_W-1:0] y_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_t         state_q, state_d;
  logic           acc_start_q, acc_start_d;
  logic [X_W-1:0] acc_x_q, acc_x_d;
  logic [Y_W-1:0] acc_y_q, acc_y_d;
  logic           res_valid_q, res_valid_d;
  logic [R_W-1:0] res_data_q, res_data_d;

`ifdef COS_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]  wdog_q, wdog_d;
  logic           res_err_q, res_err_d;
`endif

  logic push;
  logic pop;

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // The head entry leaves the FIFO on the same edge it is copied onto the accelerator bus.
  assign pop      = (state_q == S_LAUNCH);

  // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Write accepted jobs into the storage array.
  always_ff @(posedge clk) begin
    if (push) begin
      x_mem[wr_ptr_q] <= in_x;
      y_mem[wr_ptr_q] <= in_y;
    end
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sequencer next-state and registered outputs: one job in flight, results in issue order.
  always_comb begin
    state_d     = state_q;
    acc_start_d = 1'b0;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
`ifdef COS_FEED_TIMEOUT_EN
    wdog_d      = wdog_q;
    res_err_d   = res_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        acc_x_d     = x_mem[rd_ptr_q];
        acc_y_d     = y_mem[rd_ptr_q];
        acc_start_d = 1'b1;
`ifdef COS_FEED_TIMEOUT_EN
        wdog_d      = '0;
`endif
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving together with the watchdog limit still counts as a normal result.
        if (acc_done) begin
          res_data_d  = acc_out;
          res_valid_d = 1'b1;
`ifdef COS_FEED_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
          state_d     = S_HOLD;
        end
`ifdef COS_FEED_TIMEOUT_EN
        else if (wdog_q == TW'(TIMEOUT - 1)) begin
          res_data_d  = {R_W{1'b1}};
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
`ifdef COS_FEED_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
          state_d     = (count_q != '0) ? S_LAUNCH : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_start_q <= 1'b0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_start_q <= acc_start_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

`ifdef COS_FEED_TIMEOUT_EN
  // Watchdog counter and error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q    <= '0;
      res_err_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      res_err_q <= res_err_d;
    end
  end

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign acc_start = acc_start_q;
  assign acc_x     = acc_x_q;
  assign acc_y     = acc_y_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign count     = count_q;
  assign busy      = (state_q != S_IDLE) || (count_q != '0);

endmodule
